// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between the IFU and LSU, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default gives LSU fixed priority.
//
// state | meaning
// IDLE  | no transaction; a pending request is granted at the next edge
// BUSY  | mem_read_request high, waiting for mem_read_data_ready
module mem_read_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ifu_read_request_i,
    input  logic [ADDR_WIDTH-1:0] ifu_read_addr_i,
    output logic                  ifu_read_data_ready_o,
    output logic [WORD_WIDTH-1:0] ifu_read_data_o,
    input  logic                  lsu_read_request_i,
    input  logic [ADDR_WIDTH-1:0] lsu_read_addr_i,
    output logic                  lsu_read_data_ready_o,
    output logic [WORD_WIDTH-1:0] lsu_read_data_o,
    output logic                  mem_read_request_o,
    output logic [ADDR_WIDTH-1:0] mem_read_addr_o,
    input  logic                  mem_read_data_ready_i,
    input  logic [WORD_WIDTH-1:0] mem_read_data_i,
    output logic                  busy_o,
    output logic                  err_timeout_o
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic                  state_q, state_d;
    logic                  owner_lsu_q, owner_lsu_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  grant_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_ifu_pref_q, rr_ifu_pref_d;

    // On a tie, the requester not granted last wins.
    assign grant_lsu = lsu_read_request_i & (~ifu_read_request_i | ~rr_ifu_pref_q);

    always_comb begin
        rr_ifu_pref_d = rr_ifu_pref_q;
        if (state_q == STATE_IDLE && (ifu_read_request_i || lsu_read_request_i)) begin
            rr_ifu_pref_d = grant_lsu;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ifu_pref_q <= 1'b1;
        end else begin
            rr_ifu_pref_q <= rr_ifu_pref_d;
        end
    end
`else
    assign grant_lsu = lsu_read_request_i;
`endif

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        case (state_q)
            STATE_IDLE: begin
                if (ifu_read_request_i || lsu_read_request_i) begin
                    state_d     = STATE_BUSY;
                    owner_lsu_d = grant_lsu;
                    addr_d      = grant_lsu ? lsu_read_addr_i : ifu_read_addr_i;
                    cnt_d       = '0;
                end
            end
            default: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mem_read_data_ready_i) begin
                    state_d = STATE_IDLE;
                end
            end
        endcase
        // Sticky error; the transaction itself keeps waiting for memory.
        err_d = err_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= STATE_IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign mem_read_request_o    = (state_q == STATE_BUSY);
    assign busy_o                = (state_q == STATE_BUSY);
    assign mem_read_addr_o       = addr_q;
    assign err_timeout_o         = err_q;
    assign ifu_read_data_ready_o = (state_q == STATE_BUSY) & mem_read_data_ready_i & ~owner_lsu_q;
    assign lsu_read_data_ready_o = (state_q == STATE_BUSY) & mem_read_data_ready_i & owner_lsu_q;
    assign ifu_read_data_o       = mem_read_data_i;
    assign lsu_read_data_o       = mem_read_data_i;

endmodule
